// File: rtl/btn_event_pkg.sv
// Shared constants for the push-button event generator:
// FSM state encoding and bit positions of the events in the MMIO status vector.
package btn_event_pkg;

    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_PRESSED        = 3'd1;
    localparam logic [2:0] ST_LONG_HELD      = 3'd2;
    localparam logic [2:0] ST_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] ST_SECOND_PRESSED = 3'd4;
    localparam logic [2:0] ST_LOCKOUT        = 3'd5;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_CLICK   = 2;
    localparam int EV_DCLICK  = 3;
    localparam int EV_LONG    = 4;
    localparam int EV_W       = 5;

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the debounced level and reports rising/falling edges.
// Reset loads the live level so a button held through reset shows no edge.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic clean_i,
    output logic rise_o,
    output logic fall_o
);

    logic clean_q;

    always_ff @(posedge clk) begin
        clean_q <= clean_i;
    end

    assign rise_o =  clean_i & ~clean_q;
    assign fall_o = ~clean_i &  clean_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns one debounced button level into registered one-cycle event pulses:
// press, release, single click, double click and long press.
module button_event_gen
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int DCLICK_CYCLES = 15000000,
    parameter int CNT_BITS      = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic dclick_pulse,
    output logic long_pulse,
    output logic held
);

    localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] DCLICK_LAST = CNT_BITS'(DCLICK_CYCLES - 1);

    logic                rise;
    logic                fall;
    logic [2:0]          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [EV_W-1:0]     ev_q, ev_d;
    logic                held_q, held_d;
    logic                timed;

    btn_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .clean_i (clean),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Edges are tested before timeouts so an edge always wins a tie.
    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        unique case (state_q)
            ST_LOCKOUT: begin
                if (fall) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d         = ST_PRESSED;
                    ev_d[EV_PRESS]  = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d          = ST_WAIT_SECOND;
                    ev_d[EV_RELEASE] = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d       = ST_LONG_HELD;
                    ev_d[EV_LONG] = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    state_d          = ST_IDLE;
                    ev_d[EV_RELEASE] = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                if (rise) begin
                    state_d        = ST_SECOND_PRESSED;
                    ev_d[EV_PRESS] = 1'b1;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d        = ST_IDLE;
                    ev_d[EV_CLICK] = 1'b1;
                end
            end
            ST_SECOND_PRESSED: begin
                if (fall) begin
                    state_d          = ST_IDLE;
                    ev_d[EV_RELEASE] = 1'b1;
                    ev_d[EV_DCLICK]  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d        = ST_LONG_HELD;
                    ev_d[EV_CLICK] = 1'b1;
                    ev_d[EV_LONG]  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Untimed states keep the counter parked at zero so it can never wrap.
    assign timed = (state_q == ST_PRESSED) ||
                   (state_q == ST_WAIT_SECOND) ||
                   (state_q == ST_SECOND_PRESSED);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || !timed) cnt_d = '0;
    end

    assign held_d = (state_d == ST_PRESSED) ||
                    (state_d == ST_LONG_HELD) ||
                    (state_d == ST_SECOND_PRESSED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= clean ? ST_LOCKOUT : ST_IDLE;
            cnt_q   <= '0;
            ev_q    <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            held_q  <= held_d;
        end
    end

    assign press_pulse   = ev_q[EV_PRESS];
    assign release_pulse = ev_q[EV_RELEASE];
    assign click_pulse   = ev_q[EV_CLICK];
    assign dclick_pulse  = ev_q[EV_DCLICK];
    assign long_pulse    = ev_q[EV_LONG];
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short thresholds
// (LONG_CYCLES=20, DCLICK_CYCLES=10, CNT_BITS=8).
module tb_button_event_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clean = 1'b0;
  logic press_pulse, release_pulse, click_pulse;
  logic dclick_pulse, long_pulse, held;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_press = 0, n_rel = 0, n_click = 0, n_dclick = 0, n_long = 0;
  int t_press = 0, t_rel = 0, t_click = 0, t_long = 0;
  int b_press, b_rel, b_click, b_dclick, b_long;
  int held_bad;

  button_event_gen #(
    .LONG_CYCLES   (20),
    .DCLICK_CYCLES (10),
    .CNT_BITS      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clean         (clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .dclick_pulse  (dclick_pulse),
    .long_pulse    (long_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (press_pulse)   begin n_press  <= n_press + 1;  t_press <= cyc; end
    if (release_pulse) begin n_rel    <= n_rel + 1;    t_rel   <= cyc; end
    if (click_pulse)   begin n_click  <= n_click + 1;  t_click <= cyc; end
    if (dclick_pulse)  begin n_dclick <= n_dclick + 1; end
    if (long_pulse)    begin n_long   <= n_long + 1;   t_long  <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_press  = n_press;
    b_rel    = n_rel;
    b_click  = n_click;
    b_dclick = n_dclick;
    b_long   = n_long;
  endtask

  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, click_pulse,
            dclick_pulse, long_pulse, held};
  endfunction

  initial begin
    // reset with button released
    tick(3);
    chk("reset_outs", 32'(outs()), 0);
    reset = 1'b0;
    tick(2);

    // single click
    snap();
    clean = 1'b1; tick(1);
    chk("sc_press", 32'(press_pulse), 1);
    chk("sc_held", 32'(held), 1);
    tick(4);
    clean = 1'b0; tick(1);
    chk("sc_release", 32'(release_pulse), 1);
    chk("sc_held_off", 32'(held), 0);
    tick(12);
    chk("sc_click_n", 32'(n_click - b_click), 1);
    chk("sc_click_dt", 32'(t_click - t_rel), 10);
    chk("sc_dclick_n", 32'(n_dclick - b_dclick), 0);
    chk("sc_long_n", 32'(n_long - b_long), 0);

    // double click
    snap();
    clean = 1'b1; tick(5);
    clean = 1'b0; tick(4);
    clean = 1'b1; tick(5);
    clean = 1'b0; tick(1);
    chk("dc_pair", 32'({release_pulse, dclick_pulse}), 3);
    tick(15);
    chk("dc_press_n", 32'(n_press - b_press), 2);
    chk("dc_rel_n", 32'(n_rel - b_rel), 2);
    chk("dc_dclick_n", 32'(n_dclick - b_dclick), 1);
    chk("dc_click_n", 32'(n_click - b_click), 0);

    // long press
    snap();
    held_bad = 0;
    clean = 1'b1; tick(1);
    for (int i = 0; i < 29; i++) begin
      if (held !== 1'b1) held_bad++;
      tick(1);
    end
    if (held !== 1'b1) held_bad++;
    chk("lp_held", 32'(held_bad), 0);
    clean = 1'b0; tick(1);
    chk("lp_release", 32'({release_pulse, held}), 2);
    tick(15);
    chk("lp_long_n", 32'(n_long - b_long), 1);
    chk("lp_long_dt", 32'(t_long - t_press), 20);
    chk("lp_click_n", 32'(n_click - b_click), 0);

    // button held through reset
    clean = 1'b1;
    reset = 1'b1; tick(2);
    chk("hr_in_reset", 32'(outs()), 0);
    reset = 1'b0;
    snap();
    tick(8);
    clean = 1'b0; tick(5);
    chk("hr_events", 32'((n_press - b_press) + (n_rel - b_rel) +
                         (n_click - b_click) + (n_dclick - b_dclick) +
                         (n_long - b_long)), 0);
    chk("hr_held", 32'(held), 0);
    clean = 1'b1; tick(1);
    chk("hr_next_press", 32'(press_pulse), 1);
    clean = 1'b0; tick(14);

    // second press exactly at the double-click timeout
    snap();
    clean = 1'b1; tick(3);
    clean = 1'b0; tick(1);
    tick(9);
    clean = 1'b1; tick(1);
    chk("b1_press", 32'({press_pulse, click_pulse}), 2);
    clean = 1'b0; tick(1);
    chk("b1_dclick", 32'(dclick_pulse), 1);
    tick(12);
    chk("b1_click_n", 32'(n_click - b_click), 0);

    // release exactly at the long-press threshold
    snap();
    clean = 1'b1; tick(1);
    tick(19);
    clean = 1'b0; tick(1);
    chk("b2_release", 32'({release_pulse, long_pulse}), 2);
    tick(12);
    chk("b2_long_n", 32'(n_long - b_long), 0);
    chk("b2_click_n", 32'(n_click - b_click), 1);

    // reset while waiting for a second press
    snap();
    clean = 1'b1; tick(3);
    clean = 1'b0; tick(1);
    tick(3);
    reset = 1'b1; tick(1);
    chk("rw_outs", 32'(outs()), 0);
    tick(1);
    reset = 1'b0;
    tick(15);
    chk("rw_click_n", 32'(n_click - b_click), 0);
    chk("rw_rel_n", 32'(n_rel - b_rel), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Consumes the debounced, glitch-free level of one push-button and turns it into one-cycle event pulses: press, release, single click, double click and long press.
- Sits directly downstream of the debouncer, one instance per button.
- Feeds the board-control / MMIO event register logic.
- All outputs are registered.

Parameters:
LONG_CYCLES, 50000000, hold time in clk cycles before a long press fires; legal range 2 .. 2^CNT_BITS-1
DCLICK_CYCLES, 15000000, max gap in clk cycles between first release and second press for a double click; legal range 2 .. 2^CNT_BITS-1
CNT_BITS, 32, width of the shared interval counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
clean  input  1  debounced button level, 1 = pressed
press_pulse  output  1  one-cycle pulse on each press
release_pulse  output  1  one-cycle pulse on each release
click_pulse  output  1  one-cycle pulse when a single click is resolved
dclick_pulse  output  1  one-cycle pulse when a double click completes
long_pulse  output  1  one-cycle pulse when the long-press threshold is reached
held  output  1  level, 1 while the FSM considers the button pressed

Behaviour:
- Reset (reset=1 at a clk edge):
  - All outputs 0; counter 0; clean_q <= clean.
  - Next state is LOCKOUT if clean=1, else IDLE. A button held through reset generates no events.
- Edge detection:
  - rise = clean & ~clean_q; fall = ~clean & clean_q; clean_q <= clean every cycle.
- Latency: every pulse is high exactly one cycle, in the cycle after the clk edge at which the triggering condition is sampled.
- Counter rules:
  - Cleared on every state change.
  - Incremented otherwise.
  - Never wraps, because every timed state exits at its threshold.
- States and transitions:
  - LOCKOUT: fall -> IDLE; no pulses.
  - IDLE: rise -> PRESSED, press_pulse.
  - PRESSED:
    - fall -> WAIT_SECOND, release_pulse.
    - else counter==LONG_CYCLES-1 -> LONG_HELD, long_pulse.
  - LONG_HELD: fall -> IDLE, release_pulse; no click.
  - WAIT_SECOND:
    - rise -> SECOND_PRESSED, press_pulse.
    - else counter==DCLICK_CYCLES-1 -> IDLE, click_pulse.
  - SECOND_PRESSED:
    - fall -> IDLE, release_pulse + dclick_pulse in the same cycle.
    - else counter==LONG_CYCLES-1 -> LONG_HELD, click_pulse + long_pulse in the same cycle (the first tap resolves as a click).
- Simultaneous events: an edge always beats a timeout in the same cycle (edge branch taken, timeout pulse suppressed).
- held = 1 in PRESSED, LONG_HELD, SECOND_PRESSED; 0 in IDLE, WAIT_SECOND, LOCKOUT.
- Reset mid-operation:
  - Abandons any pending click/long decision with no pulse.
  - Re-enters per the reset rule above.
- Pulses never overlap except the two documented pairs.

Decomposition:
- Package btn_event_pkg:
  - state encoding constants: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED, LOCKOUT (3-bit).
  - event bit-index constants for packing the five pulses into an MMIO status vector.
- One sub-module, btn_edge_detect: clean_q register plus rise/fall outputs, with the reset-load behaviour above.
- FSM and counter stay in the top.

Test Plan (LONG_CYCLES=20, DCLICK_CYCLES=10, CNT_BITS=8):
- Single click:
  - Stimulus: clean high 5 cycles, then low.
  - Required: press_pulse one cycle after the rise; release_pulse one cycle after the fall; click_pulse exactly 10 cycles after release_pulse; no dclick/long.
- Double click:
  - Stimulus: press 5, gap 4, press 5.
  - Required: press, release, press, then release_pulse and dclick_pulse in the same cycle; no click_pulse.
- Long press:
  - Stimulus: clean held 30 cycles.
  - Required: long_pulse 20 cycles after press_pulse; held=1 throughout; release_pulse on fall; no click.
- Press held through reset:
  - Stimulus: clean=1 during reset, released 8 cycles after reset drops.
  - Required: zero pulses; state IDLE afterwards; next press yields a normal press_pulse.
- Boundaries:
  - Second press arriving in the same cycle counter==9 in WAIT_SECOND -> press_pulse, no click_pulse.
  - Fall at counter==19 in PRESSED -> release_pulse, no long_pulse.
- Reset mid-WAIT_SECOND:
  - Stimulus: reset asserted 3 cycles after a release.
  - Required: all outputs 0, no click_pulse ever emitted for that tap.
